// File: rtl/fb_pkg.sv
// Shared constants, command opcodes and FSM state encoding for the
// framebuffer rectangle-fill engine.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 160;
  localparam int unsigned FB_HEIGHT = 120;
  localparam int unsigned FB_CW     = 8;

  localparam logic [1:0] OP_FILL    = 2'd0;
  localparam logic [1:0] OP_CLEAR   = 2'd1;
  localparam logic [1:0] OP_OUTLINE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DONE
  } fb_state_e;

endpackage

// File: rtl/fb_raster_counter.sv
// Loadable row-major x/y pixel counter over an inclusive [xa..xb] x [ya..yb]
// window, with advance enable and an optional interior-row x jump (outline).
module fb_raster_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic          jump_en_i,
  input  logic [CW-1:0] xa_i,
  input  logic [CW-1:0] ya_i,
  input  logic [CW-1:0] xb_i,
  input  logic [CW-1:0] yb_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          last_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [CW-1:0] xa_q, ya_q, xb_q, yb_q;
  logic          jump_q;

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == xb_q) && (y_q == yb_q);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = xa_i;
      y_d = ya_i;
    end else if (adv_i && !last_o) begin
      // Row end wins over the jump so a one-column outline degenerates to a fill.
      if (x_q == xb_q) begin
        x_d = xa_q;
        y_d = y_q + ONE;
      end else if (jump_q && (x_q == xa_q) && (y_q != ya_q) && (y_q != yb_q)) begin
        x_d = xb_q;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      xa_q   <= '0;
      ya_q   <= '0;
      xb_q   <= '0;
      yb_q   <= '0;
      jump_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (load_i) begin
        xa_q   <= xa_i;
        ya_q   <= ya_i;
        xb_q   <= xb_i;
        yb_q   <= yb_i;
        jump_q <= jump_en_i;
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill / clear-screen drawing engine feeding the framebuffer write
// port. Optional outline drawing (cmd_op=2) is enabled by FB_RECT_OUTLINE_EN.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT,
  parameter int unsigned CW     = FB_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_x0,
  input  logic [CW-1:0] cmd_y0,
  input  logic [CW-1:0] cmd_x1,
  input  logic [CW-1:0] cmd_y1,
  input  logic [7:0]    cmd_color,
  input  logic          wr_stall,
  output logic [CW-1:0] x_data,
  output logic [CW-1:0] y_data,
  output logic [7:0]    color,
  output logic          write,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] XMAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] YMAX = CW'(HEIGHT - 1);

  fb_state_e     state_q, state_d;
  logic          cmd_ready_q, busy_q, done_q, write_q;
  logic [1:0]    op_q;
  logic [CW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [7:0]    color_q;

  logic          accept;
  logic          load;
  logic          adv;
  logic          last;
  logic          is_clear;
  logic          is_outline;
  logic          empty;
  logic [CW-1:0] xlo, xhi, ylo, yhi;
  logic [CW-1:0] xa, xb, ya, yb;

  assign accept   = cmd_valid && cmd_ready_q;
  assign is_clear = (op_q == OP_CLEAR);

`ifdef FB_RECT_OUTLINE_EN
  assign is_outline = (op_q == OP_OUTLINE);
`else
  assign is_outline = 1'b0;
`endif

  // Normalise corners, then clip the far edge; an off-screen near edge means no pixels.
  always_comb begin
    xlo = (x0_q <= x1_q) ? x0_q : x1_q;
    xhi = (x0_q <= x1_q) ? x1_q : x0_q;
    ylo = (y0_q <= y1_q) ? y0_q : y1_q;
    yhi = (y0_q <= y1_q) ? y1_q : y0_q;
    if (is_clear) begin
      xlo = '0;
      xhi = XMAX;
      ylo = '0;
      yhi = YMAX;
    end
    xa    = xlo;
    ya    = ylo;
    xb    = (xhi > XMAX) ? XMAX : xhi;
    yb    = (yhi > YMAX) ? YMAX : yhi;
    empty = (xa > XMAX) || (ya > YMAX);
  end

  assign adv = (state_q == ST_RUN) && write_q && !wr_stall;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (empty) begin
          state_d = ST_DONE;
        end else begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (adv && last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      op_q        <= OP_FILL;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      write_q     <= (state_d == ST_RUN);
      if (accept) begin
        op_q    <= cmd_op;
        x0_q    <= cmd_x0;
        y0_q    <= cmd_y0;
        x1_q    <= cmd_x1;
        y1_q    <= cmd_y1;
        color_q <= cmd_color;
      end
    end
  end

  fb_raster_counter #(
    .CW(CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .adv_i    (adv),
    .jump_en_i(is_outline),
    .xa_i     (xa),
    .ya_i     (ya),
    .xb_i     (xb),
    .yb_i     (yb),
    .x_o      (x_data),
    .y_o      (y_data),
    .last_o   (last)
  );

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign write     = write_q;
  assign color     = color_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed self-checking bench for fb_rect_fill; outline expectations follow
// FB_RECT_OUTLINE_EN.
module tb_fb_rect_fill;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [7:0] cmd_color;
  logic       wr_stall;
  logic [7:0] x_data, y_data, color;
  logic       write, busy, done;

  int nvec = 0;
  int nmis = 0;
  logic [15:0] got_q[$];

  always #5 clk = ~clk;

  fb_rect_fill #(
    .WIDTH (160),
    .HEIGHT(120),
    .CW    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_x1   (cmd_x1),
    .cmd_y1   (cmd_y1),
    .cmd_color(cmd_color),
    .wr_stall (wr_stall),
    .x_data   (x_data),
    .y_data   (y_data),
    .color    (color),
    .write    (write),
    .busy     (busy),
    .done     (done)
  );

  // Issue one command and record every accepted write. Cycle numbers are
  // counted in clock edges after the accepting edge.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] x0, y0, x1, y1, col,
                         input int max_cyc, output int nwr, output int first_c,
                         output int last_c, output int done_c, output int ndone,
                         output logic [7:0] wcol, output bit tmo);
    int c;
    bit fin;
    got_q.delete();
    nwr = 0; first_c = -1; last_c = -1; done_c = -1; ndone = 0;
    wcol = '0; tmo = 1'b0; c = 0; fin = 1'b0;
    cmd_op = op; cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
    cmd_color = col; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      c++;
      if (write && !wr_stall) begin
        if (nwr == 0) begin
          first_c = c + 1;
          wcol = color;
        end
        last_c = c + 1;
        nwr++;
        got_q.push_back({x_data, y_data});
      end
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c + 1;
      end
      if (ndone > 0 && cmd_ready) fin = 1'b1;
      if (c >= max_cyc) begin
        tmo = 1'b1;
        fin = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; wr_stall = 1'b0;
    cmd_op = '0; cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (write !== 1'b0) begin nmis++; $display("FAIL reset_write: got %b expected 0", write); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nvec++; if (done !== 1'b0) begin nmis++; $display("FAIL reset_done: got %b expected 0", done); end
    nvec++; if ({x_data, y_data, color} !== 24'h0) begin nmis++; $display("FAIL reset_xyc: got %h expected 000000", {x_data, y_data, color}); end
    rst = 1'b0;
    @(posedge clk); #1;
    nvec++; if (cmd_ready !== 1'b1) begin nmis++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_fill();
    logic [15:0] exp_px[6] = '{16'h0203, 16'h0303, 16'h0403, 16'h0204, 16'h0304, 16'h0404};
    int nwr, fc, lc, dc, nd;
    logic [7:0] wc;
    bit tmo;
    logic [15:0] g;
    run_cmd(2'd0, 8'd2, 8'd3, 8'd4, 8'd4, 8'hE0, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (tmo !== 1'b0) begin nmis++; $display("FAIL fill_timeout: got %b expected 0", tmo); end
    nvec++; if (nwr !== 6) begin nmis++; $display("FAIL fill_count: got %0d expected 6", nwr); end
    for (int i = 0; i < 6; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      nvec++; if (g !== exp_px[i]) begin nmis++; $display("FAIL fill_px%0d: got %h expected %h", i, g, exp_px[i]); end
    end
    nvec++; if (fc !== 2) begin nmis++; $display("FAIL fill_first: got %0d expected 2", fc); end
    nvec++; if (lc !== 7) begin nmis++; $display("FAIL fill_last: got %0d expected 7", lc); end
    nvec++; if (dc !== 8) begin nmis++; $display("FAIL fill_done_at: got %0d expected 8", dc); end
    nvec++; if (nd !== 1) begin nmis++; $display("FAIL fill_done_pulses: got %0d expected 1", nd); end
    nvec++; if (wc !== 8'hE0) begin nmis++; $display("FAIL fill_color: got %h expected e0", wc); end
    nvec++; if (cmd_ready !== 1'b1) begin nmis++; $display("FAIL fill_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_clear();
    int nwr, fc, lc, dc, nd, bad;
    logic [7:0] wc;
    bit tmo;
    // Corner operands are deliberately nonzero: clear must ignore them.
    run_cmd(2'd1, 8'd5, 8'd6, 8'd7, 8'd8, 8'h00, 20000, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (tmo !== 1'b0) begin nmis++; $display("FAIL clear_timeout: got %b expected 0", tmo); end
    nvec++; if (nwr !== 19200) begin nmis++; $display("FAIL clear_count: got %0d expected 19200", nwr); end
    nvec++; if (lc - fc + 1 !== 19200) begin nmis++; $display("FAIL clear_span: got %0d expected 19200", lc - fc + 1); end
    nvec++; if (dc !== lc + 1) begin nmis++; $display("FAIL clear_done_at: got %0d expected %0d", dc, lc + 1); end
    bad = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== {8'(i % 160), 8'(i / 160)}) bad++;
    nvec++; if (bad !== 0) begin nmis++; $display("FAIL clear_order: got %0d bad pixels expected 0", bad); end
    nvec++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== 16'h9F77) begin
      nmis++; $display("FAIL clear_lastpx: got %h expected 9f77", (got_q.size() == 0) ? 16'hxxxx : got_q[got_q.size()-1]);
    end
    run_cmd(2'd0, 8'd159, 8'd119, 8'd0, 8'd0, 8'h1C, 20000, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 19200) begin nmis++; $display("FAIL fullfill_count: got %0d expected 19200", nwr); end
    bad = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== {8'(i % 160), 8'(i / 160)}) bad++;
    nvec++; if (bad !== 0) begin nmis++; $display("FAIL fullfill_order: got %0d bad pixels expected 0", bad); end
    nvec++; if (nd !== 1) begin nmis++; $display("FAIL fullfill_done_pulses: got %0d expected 1", nd); end
  endtask

  task automatic test_clip();
    int nwr, fc, lc, dc, nd;
    logic [7:0] wc;
    bit tmo;
    logic [15:0] g;
    run_cmd(2'd0, 8'd170, 8'd5, 8'd158, 8'd5, 8'h3C, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 2) begin nmis++; $display("FAIL clip_count: got %0d expected 2", nwr); end
    g = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
    nvec++; if (g !== 16'h9E05) begin nmis++; $display("FAIL clip_px0: got %h expected 9e05", g); end
    g = (got_q.size() > 1) ? got_q[1] : 16'hxxxx;
    nvec++; if (g !== 16'h9F05) begin nmis++; $display("FAIL clip_px1: got %h expected 9f05", g); end
    run_cmd(2'd0, 8'd200, 8'd10, 8'd210, 8'd12, 8'hFF, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 0) begin nmis++; $display("FAIL offx_count: got %0d expected 0", nwr); end
    nvec++; if (dc !== 2) begin nmis++; $display("FAIL offx_done_at: got %0d expected 2", dc); end
    nvec++; if (tmo !== 1'b0) begin nmis++; $display("FAIL offx_timeout: got %b expected 0", tmo); end
    run_cmd(2'd0, 8'd10, 8'd130, 8'd12, 8'd125, 8'hFF, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 0) begin nmis++; $display("FAIL offy_count: got %0d expected 0", nwr); end
    run_cmd(2'd0, 8'd7, 8'd9, 8'd7, 8'd9, 8'h55, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 1) begin nmis++; $display("FAIL single_count: got %0d expected 1", nwr); end
    g = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
    nvec++; if (g !== 16'h0709) begin nmis++; $display("FAIL single_px: got %h expected 0709", g); end
    run_cmd(2'd3, 8'd6, 8'd5, 8'd5, 8'd5, 8'h55, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 2) begin nmis++; $display("FAIL op3_count: got %0d expected 2", nwr); end
  endtask

  task automatic test_stall();
    logic [15:0] exp_px[4] = '{16'h0A14, 16'h0B14, 16'h0C14, 16'h0D14};
    int c, nst, nwr, lc;
    bit stall_prev, fin, seen_done;
    logic [15:0] g;
    got_q.delete();
    c = 0; nst = 0; nwr = 0; lc = -1; stall_prev = 1'b0; fin = 1'b0; seen_done = 1'b0;
    cmd_op = 2'd0; cmd_x0 = 8'd10; cmd_y0 = 8'd20; cmd_x1 = 8'd13; cmd_y1 = 8'd20;
    cmd_color = 8'hA5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      c++;
      if (stall_prev) begin
        nvec++; if ({write, x_data, y_data, color} !== {1'b1, 16'h0B14, 8'hA5}) begin
          nmis++; $display("FAIL stall_hold%0d: got %h expected 10b14a5", nst, {write, x_data, y_data, color});
        end
      end
      wr_stall = (write && x_data == 8'd11 && nst < 3);
      if (wr_stall) nst++;
      stall_prev = wr_stall;
      if (write && !wr_stall) begin
        got_q.push_back({x_data, y_data});
        nwr++;
        lc = c + 1;
      end
      if (done) seen_done = 1'b1;
      if (seen_done && cmd_ready) fin = 1'b1;
      if (c >= 60) begin
        nvec++; nmis++; $display("FAIL stall_timeout: got %0d cycles expected completion", c);
        fin = 1'b1;
      end
    end
    wr_stall = 1'b0;
    nvec++; if (nwr !== 4) begin nmis++; $display("FAIL stall_count: got %0d expected 4", nwr); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      nvec++; if (g !== exp_px[i]) begin nmis++; $display("FAIL stall_px%0d: got %h expected %h", i, g, exp_px[i]); end
    end
    nvec++; if (lc !== 8) begin nmis++; $display("FAIL stall_last: got %0d expected 8", lc); end
  endtask

  task automatic test_reset_mid();
    int nwr, fc, lc, dc, nd, stray;
    logic [7:0] wc;
    bit tmo;
    logic [15:0] g;
    cmd_op = 2'd1; cmd_color = 8'h77; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    nvec++; if (write !== 1'b1) begin nmis++; $display("FAIL mid_running: got %b expected 1", write); end
    rst = 1'b1;
    @(posedge clk); #1;
    nvec++; if ({write, busy, done} !== 3'b000) begin nmis++; $display("FAIL mid_abort: got %b expected 000", {write, busy, done}); end
    rst = 1'b0;
    @(posedge clk); #1;
    nvec++; if (cmd_ready !== 1'b1) begin nmis++; $display("FAIL mid_ready: got %b expected 1", cmd_ready); end
    stray = 0;
    repeat (5) begin
      if (write !== 1'b0) stray++;
      @(posedge clk); #1;
    end
    nvec++; if (stray !== 0) begin nmis++; $display("FAIL mid_stray: got %0d writes expected 0", stray); end
    run_cmd(2'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'h33, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 2) begin nmis++; $display("FAIL mid_next_count: got %0d expected 2", nwr); end
    g = (got_q.size() > 1) ? got_q[1] : 16'hxxxx;
    nvec++; if (g !== 16'h0100) begin nmis++; $display("FAIL mid_next_px1: got %h expected 0100", g); end
    nvec++; if (wc !== 8'h33) begin nmis++; $display("FAIL mid_next_color: got %h expected 33", wc); end
  endtask

  task automatic test_outline();
`ifdef FB_RECT_OUTLINE_EN
    localparam int N = 10;
    logic [15:0] exp_px[N] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0001,
                               16'h0301, 16'h0002, 16'h0102, 16'h0202, 16'h0302};
`else
    localparam int N = 12;
    logic [15:0] exp_px[N] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0001, 16'h0101,
                               16'h0201, 16'h0301, 16'h0002, 16'h0102, 16'h0202, 16'h0302};
`endif
    int nwr, fc, lc, dc, nd;
    logic [7:0] wc;
    bit tmo;
    logic [15:0] g;
    run_cmd(2'd2, 8'd0, 8'd0, 8'd3, 8'd2, 8'h92, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== N) begin nmis++; $display("FAIL outline_count: got %0d expected %0d", nwr, N); end
    for (int i = 0; i < N; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      nvec++; if (g !== exp_px[i]) begin nmis++; $display("FAIL outline_px%0d: got %h expected %h", i, g, exp_px[i]); end
    end
    nvec++; if (lc - fc + 1 !== N) begin nmis++; $display("FAIL outline_span: got %0d expected %0d", lc - fc + 1, N); end
    run_cmd(2'd2, 8'd4, 8'd1, 8'd4, 8'd3, 8'h92, 50, nwr, fc, lc, dc, nd, wc, tmo);
    nvec++; if (nwr !== 3) begin nmis++; $display("FAIL outline_1col_count: got %0d expected 3", nwr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_clear();
    test_clip();
    test_stall();
    test_reset_mid();
    test_outline();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
